// File: rtl/pong_game_engine.sv
// pong_game_engine
//   Pong game-state engine: ball physics, paddle movement, paddle/wall
//   collision, scoring and the IDLE/SERVE/PLAY/OVER match sequence.
//   State advances only on cycles where frame_tick is high.
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   frame_tick        : one-cycle per-frame strobe, the only advancing cycle
//   start             : any button pressed (sampled on tick cycles only)
//   stick_y1/stick_y2 : raw stick Y, 128 = centre, larger = up
//   ball_x/ball_y     : ball top-left position
//   p1_y/p2_y         : paddle top positions
//   p1_score/p2_score : saturating scores
//   game_state        : 0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
//   game_over         : high while in OVER
//
// Optional feature macro: PONG_SPEEDUP_EN -- each paddle hit raises the
//   horizontal speed by 1 up to MAX_VX; speed returns to BALL_VX on serve.
module pong_game_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_W     = 5,
  parameter int PADDLE_H     = 100,
  parameter int BALL_SIZE    = 10,
  parameter int BALL_VX      = 4,
  parameter int STICK_SHIFT  = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int MAX_VX       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [7:0]  stick_y1,
  input  logic [7:0]  stick_y2,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic [7:0]  p1_score,
  output logic [7:0]  p2_score,
  output logic [1:0]  game_state,
  output logic        game_over
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;

  localparam logic [10:0] BALL_X0 = 11'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [10:0] BALL_Y0 = 11'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [10:0] PAD_Y0  = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] PAD_MAX = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] BY_MAX  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] BX_LHIT = 11'(PADDLE_W);
  localparam logic [10:0] BX_RHIT = 11'(SCREEN_W - PADDLE_W - BALL_SIZE);

  localparam logic signed [11:0] S_BY_MAX  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] S_PW      = 12'(PADDLE_W);
  localparam logic signed [11:0] S_BS      = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_HALF    = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] S_RLINE   = 12'(SCREEN_W - PADDLE_W);
  localparam logic signed [11:0] S_BX_MISS = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] S_H3      = 12'(PADDLE_H / 3);
  localparam logic signed [11:0] S_H23     = 12'(2 * PADDLE_H / 3);
  localparam logic [11:0]        U_BS      = 12'(BALL_SIZE);
  localparam logic [11:0]        U_PH      = 12'(PADDLE_H);

  // vx register sized for the larger of the start speed and the speed cap
  localparam int VX_TOP = (MAX_VX > BALL_VX) ? MAX_VX : BALL_VX;
  localparam int VX_W   = $clog2(VX_TOP + 1);
  localparam int CNT_W  = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t              r_state;
  logic [10:0]         r_ball_x, r_ball_y, r_p1_y, r_p2_y;
  logic [7:0]          r_p1_score, r_p2_score;
  logic                r_game_over;
  logic signed [11:0]  r_vy;
  logic [VX_W-1:0]     r_vx;
  logic                r_dir_r;   // 0 = moving left, 1 = moving right
  logic [CNT_W-1:0]    r_cnt;

  logic [10:0]         w_p1_n, w_p2_n, w_bx_n, w_by_n;
  logic signed [11:0]  w_ny, w_nx, w_vx, w_vy_n, w_off1, w_off2, w_hit_off;
  logic                w_ov1, w_ov2, w_hit, w_dir_n, w_p1_pt, w_p2_pt;
  logic [7:0]          w_s1_inc, w_s2_inc;

  function automatic logic [10:0] paddle_next(input logic [10:0] p, input logic [7:0] s);
    logic [7:0]  d;
    logic [11:0] sum;
    paddle_next = p;
    if (s >= 8'd128) begin
      d = 8'(s - 8'd128) >> STICK_SHIFT;
      paddle_next = (p >= {3'b000, d}) ? p - {3'b000, d} : '0;
    end else begin
      d   = 8'(8'd128 - s) >> STICK_SHIFT;
      sum = {1'b0, p} + {4'b0000, d};
      paddle_next = (sum > {1'b0, PAD_MAX}) ? PAD_MAX : sum[10:0];
    end
  endfunction

  always_comb begin
    w_p1_n   = paddle_next(r_p1_y, stick_y1);
    w_p2_n   = paddle_next(r_p2_y, stick_y2);
    w_s1_inc = (r_p1_score == 8'hFF) ? 8'hFF : r_p1_score + 8'd1;
    w_s2_inc = (r_p2_score == 8'hFF) ? 8'hFF : r_p2_score + 8'd1;

    // overlap and hit offset use the pre-tick ball and paddle positions
    w_ov1  = (({1'b0, r_ball_y} + U_BS) > {1'b0, r_p1_y}) && ({1'b0, r_ball_y} < ({1'b0, r_p1_y} + U_PH));
    w_ov2  = (({1'b0, r_ball_y} + U_BS) > {1'b0, r_p2_y}) && ({1'b0, r_ball_y} < ({1'b0, r_p2_y} + U_PH));
    w_off1 = $signed({1'b0, r_ball_y}) + S_HALF - $signed({1'b0, r_p1_y});
    w_off2 = $signed({1'b0, r_ball_y}) + S_HALF - $signed({1'b0, r_p2_y});

    w_ny   = $signed({1'b0, r_ball_y}) + r_vy;
    w_by_n = w_ny[10:0];
    w_vy_n = r_vy;
    if (w_ny < 12'sd0) begin
      w_by_n = '0;
      w_vy_n = -r_vy;
    end else if (w_ny > S_BY_MAX) begin
      w_by_n = BY_MAX;
      w_vy_n = -r_vy;
    end

    w_vx      = 12'(r_vx);
    w_bx_n    = r_ball_x;
    w_dir_n   = r_dir_r;
    w_hit     = 1'b0;
    w_hit_off = '0;
    w_p1_pt   = 1'b0;
    w_p2_pt   = 1'b0;
    if (!r_dir_r) begin
      w_nx = $signed({1'b0, r_ball_x}) - w_vx;
      if (w_nx <= S_PW && w_ov1) begin
        w_bx_n = BX_LHIT; w_dir_n = 1'b1; w_hit = 1'b1; w_hit_off = w_off1;
      end else if (w_nx <= 12'sd0) begin
        w_p2_pt = 1'b1;
      end else begin
        w_bx_n = w_nx[10:0];
      end
    end else begin
      w_nx = $signed({1'b0, r_ball_x}) + w_vx;
      if (w_nx + S_BS >= S_RLINE && w_ov2) begin
        w_bx_n = BX_RHIT; w_dir_n = 1'b0; w_hit = 1'b1; w_hit_off = w_off2;
      end else if (w_nx >= S_BX_MISS) begin
        w_p1_pt = 1'b1;
      end else begin
        w_bx_n = w_nx[10:0];
      end
    end

    // a paddle hit sets vy from the hit angle; the wall clamp still applies to ball_y
    if (w_hit) begin
      if (w_hit_off < S_H3)        w_vy_n = -12'sd2;
      else if (w_hit_off >= S_H23) w_vy_n = 12'sd2;
      else                         w_vy_n = 12'sd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ball_x    <= BALL_X0;
      r_ball_y    <= BALL_Y0;
      r_p1_y      <= PAD_Y0;
      r_p2_y      <= PAD_Y0;
      r_p1_score  <= '0;
      r_p2_score  <= '0;
      r_game_over <= 1'b0;
      r_vy        <= '0;
      r_vx        <= VX_W'(BALL_VX);
      r_dir_r     <= 1'b0;
      r_cnt       <= '0;
    end else if (frame_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_SERVE;
        end
        S_SERVE: begin
          r_p1_y   <= w_p1_n;
          r_p2_y   <= w_p2_n;
          r_ball_x <= BALL_X0;
          r_ball_y <= BALL_Y0;
          r_vy     <= '0;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_PLAY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PLAY: begin
          r_p1_y   <= w_p1_n;
          r_p2_y   <= w_p2_n;
          r_ball_x <= w_bx_n;
          r_ball_y <= w_by_n;
          r_vy     <= w_vy_n;
          r_dir_r  <= w_dir_n;
`ifdef PONG_SPEEDUP_EN
          if (w_hit && r_vx < VX_W'(MAX_VX)) r_vx <= r_vx + 1'b1;
`endif
          if (w_p1_pt || w_p2_pt) begin
            // the next serve heads toward the player who conceded
            r_ball_x <= BALL_X0;
            r_ball_y <= BALL_Y0;
            r_vy     <= '0;
            r_vx     <= VX_W'(BALL_VX);
            r_cnt    <= '0;
            r_dir_r  <= w_p1_pt;
            if (w_p2_pt) r_p2_score <= w_s2_inc;
            else         r_p1_score <= w_s1_inc;
            if ((w_p2_pt ? w_s2_inc : w_s1_inc) == 8'(WIN_SCORE)) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state <= S_SERVE;
            end
          end
        end
        S_OVER: begin
          if (start) begin
            r_state     <= S_SERVE;
            r_game_over <= 1'b0;
            r_p1_score  <= '0;
            r_p2_score  <= '0;
            r_p1_y      <= PAD_Y0;
            r_p2_y      <= PAD_Y0;
            r_ball_x    <= BALL_X0;
            r_ball_y    <= BALL_Y0;
            r_vy        <= '0;
            r_vx        <= VX_W'(BALL_VX);
            r_dir_r     <= 1'b0;
            r_cnt       <= '0;
          end
        end
      endcase
    end
  end

  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign p1_y       = r_p1_y;
  assign p2_y       = r_p2_y;
  assign p1_score   = r_p1_score;
  assign p2_score   = r_p2_score;
  assign game_state = r_state;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine
//   Directed scenario for pong_game_engine with hand-computed checkpoints.
//   Stimulus pushes expected values into a queue; a monitor pops and
//   compares after every tick or reset edge.
module tb_pong_game_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  stick_y1 = 8'd128;
  logic [7:0]  stick_y2 = 8'd128;
  logic [10:0] ball_x, ball_y, p1_y, p2_y;
  logic [7:0]  p1_score, p2_score;
  logic [1:0]  game_state;
  logic        game_over;

  pong_game_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .stick_y1(stick_y1), .stick_y2(stick_y2),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .p1_score(p1_score), .p2_score(p2_score),
    .game_state(game_state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  localparam int M_BX = 1, M_BY = 2, M_P1 = 4, M_P2 = 8;
  localparam int M_S1 = 16, M_S2 = 32, M_GS = 64, M_GO = 128, M_ALL = 255;

  typedef struct {
    string name;
    int    mask;
    int    bx, by, p1, p2, s1, s2, gs, go;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t mk(input string n, input int m, input int bx, input int by,
                              input int p1, input int p2, input int s1, input int s2,
                              input int gs, input int go);
    exp_t e;
    e.name = n; e.mask = m;
    e.bx = bx; e.by = by; e.p1 = p1; e.p2 = p2;
    e.s1 = s1; e.s2 = s2; e.gs = gs; e.go = go;
    return e;
  endfunction

  function automatic exp_t none();
    return mk("none", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic cmp(input string n, input string f, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s.%s: got %0d, expected %0d", n, f, got, want);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty: got no expectation, expected one queued");
    end else begin
      e = q.pop_front();
      if ((e.mask & M_BX) != 0) cmp(e.name, "ball_x", int'(ball_x), e.bx);
      if ((e.mask & M_BY) != 0) cmp(e.name, "ball_y", int'(ball_y), e.by);
      if ((e.mask & M_P1) != 0) cmp(e.name, "p1_y", int'(p1_y), e.p1);
      if ((e.mask & M_P2) != 0) cmp(e.name, "p2_y", int'(p2_y), e.p2);
      if ((e.mask & M_S1) != 0) cmp(e.name, "p1_score", int'(p1_score), e.s1);
      if ((e.mask & M_S2) != 0) cmp(e.name, "p2_score", int'(p2_score), e.s2);
      if ((e.mask & M_GS) != 0) cmp(e.name, "game_state", int'(game_state), e.gs);
      if ((e.mask & M_GO) != 0) cmp(e.name, "game_over", int'(game_over), e.go);
    end
  endtask

  // monitor: outputs settle after a tick or reset edge; sample on the next negedge
  initial begin
    forever begin
      @(posedge clk);
      if (frame_tick || rst) begin
        @(negedge clk);
        check_front();
      end
    end
  end

  task automatic tick(input logic [7:0] s1, input logic [7:0] s2, input logic st, input exp_t e);
    @(negedge clk);
    stick_y1 = s1; stick_y2 = s2; start = st; frame_tick = 1'b1;
    q.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input string n);
    @(negedge clk);
    rst = 1'b1;
    q.push_back(mk(n, M_ALL, 315, 235, 190, 190, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // one serve plus a rally in which P1's paddle sits at the top, so P2 scores
  task automatic miss_rally(input int r);
    for (int k = 1; k <= 60; k++) tick(8'd255, 8'd128, 1'b0, none());
    for (int j = 1; j <= 79; j++) begin
      if (j == 79 && r < 7)
        tick(8'd255, 8'd128, 1'b0, mk($sformatf("miss_%0d", r), M_BX|M_P1|M_S1|M_S2|M_GS|M_GO,
                                       315, 0, 0, 0, 0, r, 1, 0));
      else if (j == 79)
        tick(8'd255, 8'd128, 1'b0, mk("p2_wins", M_S1|M_S2|M_GS|M_GO, 0, 0, 0, 0, 0, 7, 3, 1));
      else
        tick(8'd255, 8'd128, 1'b0, none());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset("reset0");

    // IDLE holds everything without start
    for (int i = 0; i < 10; i++) begin
      if (i == 9) tick(8'd255, 8'd0, 1'b0, mk("idle_hold", M_ALL, 315, 235, 190, 190, 0, 0, 0, 0));
      else        tick(8'd255, 8'd0, 1'b0, none());
    end

    // start outside a tick cycle is ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tick(8'd128, 8'd128, 1'b0, mk("start_off_tick", M_GS, 0, 0, 0, 0, 0, 0, 0, 0));

    // start -> SERVE; paddles do not move on the IDLE tick
    tick(8'd255, 8'd128, 1'b1, mk("start_to_serve", M_BX|M_BY|M_P1|M_GS, 315, 235, 190, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 60; k++) begin
      if (k == 1)       tick(8'd255, 8'd128, 1'b0, mk("serve_p1_step", M_P1|M_GS, 0, 0, 187, 0, 0, 0, 1, 0));
      else if (k == 59) tick(8'd255, 8'd128, 1'b0, mk("serve_59", M_P1|M_GS, 0, 0, 13, 0, 0, 0, 1, 0));
      else if (k == 60) tick(8'd255, 8'd128, 1'b0, mk("serve_to_play", M_BX|M_BY|M_P1|M_P2|M_GS, 315, 235, 10, 190, 0, 0, 2, 0));
      else              tick(8'd255, 8'd128, 1'b0, none());
    end

    // rally 1: P1 paddle climbs to 0 and clamps; ball misses
    for (int j = 1; j <= 79; j++) begin
      if (j == 1)       tick(8'd255, 8'd128, 1'b0, mk("play_first_move", M_BX|M_BY|M_P1, 311, 235, 7, 0, 0, 0, 0, 0));
      else if (j == 4)  tick(8'd255, 8'd128, 1'b0, mk("p1_reach_0", M_P1, 0, 0, 0, 0, 0, 0, 0, 0));
      else if (j == 5)  tick(8'd255, 8'd128, 1'b0, mk("p1_clamp_0", M_P1, 0, 0, 0, 0, 0, 0, 0, 0));
      else if (j == 78) tick(8'd255, 8'd128, 1'b0, mk("ball_at_3", M_BX|M_S2|M_GS, 3, 0, 0, 0, 0, 0, 2, 0));
      else if (j == 79) tick(8'd255, 8'd128, 1'b0, mk("miss_p2_scores", M_BX|M_BY|M_S1|M_S2|M_GS|M_GO, 315, 235, 0, 0, 0, 1, 1, 0));
      else              tick(8'd255, 8'd128, 1'b0, none());
    end

    // serve 2: P1 paddle moves down 4 per tick from 0 to 240
    for (int k = 1; k <= 60; k++) begin
      if (k == 60) tick(8'd0, 8'd128, 1'b0, mk("serve2_to_play", M_BX|M_P1|M_GS, 315, 0, 240, 0, 0, 0, 2, 0));
      else         tick(8'd0, 8'd128, 1'b0, none());
    end

    // rally 2: ball served toward P1, hits paddle top third -> vy=-2, heads right
    for (int j = 1; j <= 79; j++) begin
      if (j == 1)       tick(8'd128, 8'd128, 1'b0, mk("serve_toward_p1", M_BX|M_P1, 311, 0, 240, 0, 0, 0, 0, 0));
      else if (j == 78) tick(8'd128, 8'd128, 1'b0, mk("p1_hit", M_BX|M_BY|M_S2|M_GS, 5, 235, 0, 0, 0, 1, 2, 0));
      else if (j == 79) tick(8'd128, 8'd128, 1'b0, mk("after_hit", M_BX|M_BY, 9, 233, 0, 0, 0, 0, 0, 0));
      else              tick(8'd128, 8'd128, 1'b0, none());
    end

    // reset mid-PLAY
    do_reset("reset_mid_play");

    // new match: P2 wins 7-0
    tick(8'd255, 8'd128, 1'b1, mk("restart_serve", M_GS, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int r = 1; r <= 7; r++) miss_rally(r);

    // OVER freezes paddles; start clears the match
    tick(8'd0, 8'd0, 1'b0, mk("over_frozen", M_P1|M_P2|M_S2|M_GS|M_GO, 0, 0, 0, 190, 0, 7, 3, 1));
    tick(8'd128, 8'd128, 1'b1, mk("over_restart", M_ALL, 315, 235, 190, 190, 0, 0, 1, 0));
    tick(8'd255, 8'd128, 1'b0, mk("serve_again", M_P1|M_GS, 0, 0, 187, 0, 0, 0, 1, 0));

    repeat (4) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
